// File: rtl/generic_sync_dp_mem.sv
// generic_sync_dp_mem: simple-dual-port synchronous RAM.
//   Port A: read/write with byte enables. Port B: read-only.
//   READ_MODE selects old (0) or new (1) data on a same-address read during
//   a port-A write; OUT_REG adds a second output register stage.
//   After every reset a clear sequencer writes CLEAR_VALUE to all words while
//   busy is high; port commands are ignored during that time.
//   Optional feature macro: GENERIC_MEM_PARITY_EN (per-byte even parity,
//   a_perr/b_perr outputs and the a_perr_inj input).
//
// Handshake: there is no back-pressure. A command is accepted on any rising
// edge where busy is low and the port's cs is high. Its result appears with
// a one-cycle valid pulse after the read latency (1, or 2 with OUT_REG=1),
// and dout keeps the last result until the next valid pulse.
module generic_sync_dp_mem #(
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    RAM_DEPTH   = 1 << ADDR_WIDTH,
   parameter int                    READ_MODE   = 0,
   parameter int                    OUT_REG     = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    busy,
   input  logic                    a_cs,
   input  logic                    a_we,
   input  logic [DATA_WIDTH/8-1:0] a_be,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [DATA_WIDTH-1:0]   a_din,
   output logic [DATA_WIDTH-1:0]   a_dout,
   output logic                    a_valid,
   input  logic                    b_cs,
   input  logic [ADDR_WIDTH-1:0]   b_addr,
   output logic [DATA_WIDTH-1:0]   b_dout,
   output logic                    b_valid
`ifdef GENERIC_MEM_PARITY_EN
   ,
   input  logic                    a_perr_inj,
   output logic [DATA_WIDTH/8-1:0] a_perr,
   output logic [DATA_WIDTH/8-1:0] b_perr
`endif
);

   localparam int                    NB        = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   clr_ptr;

   logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

   logic                    running;
   logic                    a_in_range;
   logic                    b_in_range;
   logic                    a_rd;
   logic                    a_wr;
   logic                    b_rd;
   logic                    b_hits_write;
   logic [DATA_WIDTH-1:0]   a_old;
   logic [DATA_WIDTH-1:0]   b_old;
   logic [DATA_WIDTH-1:0]   a_merged;
   logic [DATA_WIDTH-1:0]   a_word;
   logic [DATA_WIDTH-1:0]   b_word;

   // First output stage (the only stage when OUT_REG = 0)
   logic                    a_s1_valid;
   logic [DATA_WIDTH-1:0]   a_s1_data;
   logic                    b_s1_valid;
   logic [DATA_WIDTH-1:0]   b_s1_data;

`ifdef GENERIC_MEM_PARITY_EN
   logic [NB-1:0]           par_mem [RAM_DEPTH];
   logic [NB-1:0]           a_par_old;
   logic [NB-1:0]           b_par_old;
   logic [NB-1:0]           a_par_merged;
   logic [NB-1:0]           a_perr_word;
   logic [NB-1:0]           b_perr_word;
   logic [NB-1:0]           a_s1_perr;
   logic [NB-1:0]           b_s1_perr;
   logic [NB-1:0]           a_perr_q;
   logic [NB-1:0]           b_perr_q;

   // Even parity per byte: the stored bit equals the XOR of the byte.
   function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] w);
      logic [NB-1:0] p;
      p = '0;
      for (int i = 0; i < NB; i++) begin
         p[i] = ^w[8*i +: 8];
      end
      return p;
   endfunction
`endif

   // Clear sequencer state register and sweep pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state <= state_next;
         if (state == CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
         end
      end
   end

   // Next state and busy: the sweep ends on the cycle that writes the last word
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      case (state)
         CLEAR: begin
            if (clr_ptr == LAST_ADDR) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = rst;
         end
         default: begin
            state_next = CLEAR;
         end
      endcase
   end

   // Command decode, byte merge and read-during-write selection
   always_comb begin
      running      = (state == RUN);
      a_in_range   = ({1'b0, a_addr} < DEPTH_W);
      b_in_range   = ({1'b0, b_addr} < DEPTH_W);
      a_rd         = running & a_cs;
      b_rd         = running & b_cs;
      a_wr         = running & a_cs & a_we & a_in_range;
      b_hits_write = a_wr & (a_addr == b_addr);

      a_old = '0;
      if (a_in_range) begin
         a_old = mem[a_addr];
      end
      b_old = '0;
      if (b_in_range) begin
         b_old = mem[b_addr];
      end

      a_merged = a_old;
      for (int i = 0; i < NB; i++) begin
         if (a_be[i]) begin
            a_merged[8*i +: 8] = a_din[8*i +: 8];
         end
      end

      // Out-of-range reads fall through with a_old/b_old = 0
      if ((READ_MODE != 0) && a_wr) begin
         a_word = a_merged;
      end else begin
         a_word = a_old;
      end
      if ((READ_MODE != 0) && b_hits_write) begin
         b_word = a_merged;
      end else begin
         b_word = b_old;
      end
   end

   // Array write: clear sweep has priority, otherwise byte-enabled port-A write
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            mem[clr_ptr] <= CLEAR_VALUE;
         end else if (a_wr) begin
            for (int i = 0; i < NB; i++) begin
               if (a_be[i]) begin
                  mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
               end
            end
         end
      end
   end

`ifdef GENERIC_MEM_PARITY_EN
   // Parity lookup and check for both ports, following the same data selection
   always_comb begin
      a_par_old = '0;
      if (a_in_range) begin
         a_par_old = par_mem[a_addr];
      end
      b_par_old = '0;
      if (b_in_range) begin
         b_par_old = par_mem[b_addr];
      end

      a_par_merged = a_par_old;
      for (int i = 0; i < NB; i++) begin
         if (a_be[i]) begin
            a_par_merged[i] = (^a_din[8*i +: 8]) ^ a_perr_inj;
         end
      end

      if ((READ_MODE != 0) && a_wr) begin
         a_perr_word = a_par_merged ^ byte_parity(a_merged);
      end else begin
         a_perr_word = a_par_old ^ byte_parity(a_old);
      end
      if ((READ_MODE != 0) && b_hits_write) begin
         b_perr_word = a_par_merged ^ byte_parity(a_merged);
      end else begin
         b_perr_word = b_par_old ^ byte_parity(b_old);
      end
   end

   // Parity array write, mirroring the data array write
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            par_mem[clr_ptr] <= byte_parity(CLEAR_VALUE);
         end else if (a_wr) begin
            for (int i = 0; i < NB; i++) begin
               if (a_be[i]) begin
                  par_mem[a_addr][i] <= a_par_merged[i];
               end
            end
         end
      end
   end

   // First-stage parity flags travel with the read data
   always_ff @(posedge clk) begin
      if (rst) begin
         a_s1_perr <= '0;
         b_s1_perr <= '0;
      end else begin
         if (a_rd) begin
            a_s1_perr <= a_perr_word;
         end
         if (b_rd) begin
            b_s1_perr <= b_perr_word;
         end
      end
   end

   assign a_perr = a_valid ? a_perr_q : '0;
   assign b_perr = b_valid ? b_perr_q : '0;
`endif

   // First output stage: valid pulses per accepted read, data held otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         a_s1_valid <= 1'b0;
         a_s1_data  <= '0;
         b_s1_valid <= 1'b0;
         b_s1_data  <= '0;
      end else begin
         a_s1_valid <= a_rd;
         b_s1_valid <= b_rd;
         if (a_rd) begin
            a_s1_data <= a_word;
         end
         if (b_rd) begin
            b_s1_data <= b_word;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                  a_s2_valid;
         logic [DATA_WIDTH-1:0] a_s2_data;
         logic                  b_s2_valid;
         logic [DATA_WIDTH-1:0] b_s2_data;
`ifdef GENERIC_MEM_PARITY_EN
         logic [NB-1:0]         a_s2_perr;
         logic [NB-1:0]         b_s2_perr;
`endif

         // Second output stage: forwards a stage-1 result one cycle later
         always_ff @(posedge clk) begin
            if (rst) begin
               a_s2_valid <= 1'b0;
               a_s2_data  <= '0;
               b_s2_valid <= 1'b0;
               b_s2_data  <= '0;
`ifdef GENERIC_MEM_PARITY_EN
               a_s2_perr  <= '0;
               b_s2_perr  <= '0;
`endif
            end else begin
               a_s2_valid <= a_s1_valid;
               b_s2_valid <= b_s1_valid;
               if (a_s1_valid) begin
                  a_s2_data <= a_s1_data;
`ifdef GENERIC_MEM_PARITY_EN
                  a_s2_perr <= a_s1_perr;
`endif
               end
               if (b_s1_valid) begin
                  b_s2_data <= b_s1_data;
`ifdef GENERIC_MEM_PARITY_EN
                  b_s2_perr <= b_s1_perr;
`endif
               end
            end
         end

         assign a_valid = a_s2_valid;
         assign a_dout  = a_s2_data;
         assign b_valid = b_s2_valid;
         assign b_dout  = b_s2_data;
`ifdef GENERIC_MEM_PARITY_EN
         assign a_perr_q = a_s2_perr;
         assign b_perr_q = b_s2_perr;
`endif
      end else begin : g_no_out_reg
         assign a_valid = a_s1_valid;
         assign a_dout  = a_s1_data;
         assign b_valid = b_s1_valid;
         assign b_dout  = b_s1_data;
`ifdef GENERIC_MEM_PARITY_EN
         assign a_perr_q = a_s1_perr;
         assign b_perr_q = b_s1_perr;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_generic_sync_dp_mem.sv
// Bench for generic_sync_dp_mem. Two instances share all inputs:
//   dut0: 16 words, read-first, no output register (latency 1)
//   dut1: 12 words (addresses 12..15 out of range), write-first, OUT_REG=1
// A behavioural model (word arrays, a countdown for the clear period and a
// latency delay line) predicts busy/valid/dout of both after every edge.
module tb_generic_sync_dp_mem;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int NB = DW / 8;
   localparam int DEPTH [2] = '{16, 12};
   localparam int RMODE [2] = '{0, 1};
   localparam int LAT   [2] = '{1, 2};

   typedef struct packed {
      logic          v;
      logic [DW-1:0] d;
   } rd_t;

   typedef struct packed {
      logic          a_we;
      logic [NB-1:0] be;
      logic [AW-1:0] aa;
      logic [DW-1:0] din;
      logic [AW-1:0] ba;
      logic [DW-1:0] ea0;
      logic [DW-1:0] ea1;
      logic [DW-1:0] eb0;
      logic [DW-1:0] eb1;
   } vec_t;

   // ---------------- clock / reset / stimulus signals ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_cs = 1'b0;
   logic          a_we = 1'b0;
   logic [NB-1:0] a_be = '0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_din = '0;
   logic          b_cs = 1'b0;
   logic [AW-1:0] b_addr = '0;

   logic          busy0, busy1;
   logic          a_valid0, a_valid1, b_valid0, b_valid1;
   logic [DW-1:0] a_dout0, a_dout1, b_dout0, b_dout1;
`ifdef GENERIC_MEM_PARITY_EN
   logic          a_perr_inj = 1'b0;
   logic [NB-1:0] a_perr0, b_perr0, a_perr1, b_perr1;
`endif

   always #5 clk = ~clk;

   generic_sync_dp_mem #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(16), .READ_MODE(0), .OUT_REG(0)
   ) dut0 (
      .clk(clk), .rst(rst), .busy(busy0),
      .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout0), .a_valid(a_valid0),
      .b_cs(b_cs), .b_addr(b_addr), .b_dout(b_dout0), .b_valid(b_valid0)
`ifdef GENERIC_MEM_PARITY_EN
      , .a_perr_inj(a_perr_inj), .a_perr(a_perr0), .b_perr(b_perr0)
`endif
   );

   generic_sync_dp_mem #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(12), .READ_MODE(1), .OUT_REG(1)
   ) dut1 (
      .clk(clk), .rst(rst), .busy(busy1),
      .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout1), .a_valid(a_valid1),
      .b_cs(b_cs), .b_addr(b_addr), .b_dout(b_dout1), .b_valid(b_valid1)
`ifdef GENERIC_MEM_PARITY_EN
      , .a_perr_inj(a_perr_inj), .a_perr(a_perr1), .b_perr(b_perr1)
`endif
   );

   // ---------------- scoreboard / model state ----------------
   int            n_checks = 0;
   int            n_err = 0;
   logic          checking = 1'b0;
   logic [DW-1:0] mem_m [2][16];
   int            cnt_m [2] = '{0, 0};
   rd_t           slot_a [2];
   rd_t           slot_b [2];
   logic          exp_busy [2];
   logic          exp_av [2];
   logic          exp_bv [2];
   logic [DW-1:0] exp_ad [2];
   logic [DW-1:0] exp_bd [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of one rising edge for both instances
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         rd_t           ra, rb, pa, pb;
         logic [DW-1:0] olda, oldb, merged;
         logic          wr;
         if (rst) begin
            cnt_m[d]  = DEPTH[d];
            slot_a[d] = '0;
            slot_b[d] = '0;
            exp_av[d] = 1'b0;
            exp_bv[d] = 1'b0;
            exp_ad[d] = '0;
            exp_bd[d] = '0;
         end else begin
            ra = '0;
            rb = '0;
            if (cnt_m[d] > 0) begin
               cnt_m[d]--;
               if (cnt_m[d] == 0) begin
                  for (int i = 0; i < 16; i++) mem_m[d][i] = '0;
               end
            end else begin
               olda = (int'(a_addr) < DEPTH[d]) ? mem_m[d][a_addr] : '0;
               oldb = (int'(b_addr) < DEPTH[d]) ? mem_m[d][b_addr] : '0;
               merged = olda;
               for (int i = 0; i < NB; i++) begin
                  if (a_be[i]) merged[8*i +: 8] = a_din[8*i +: 8];
               end
               wr   = a_cs && a_we && (int'(a_addr) < DEPTH[d]);
               ra.v = a_cs;
               ra.d = (wr && RMODE[d] == 1) ? merged : olda;
               rb.v = b_cs;
               rb.d = (wr && RMODE[d] == 1 && a_addr == b_addr) ? merged : oldb;
               if (wr) mem_m[d][a_addr] = merged;
            end
            if (LAT[d] == 2) begin
               pa = slot_a[d];
               pb = slot_b[d];
               slot_a[d] = ra;
               slot_b[d] = rb;
            end else begin
               pa = ra;
               pb = rb;
            end
            exp_av[d] = pa.v;
            exp_bv[d] = pb.v;
            if (pa.v) exp_ad[d] = pa.d;
            if (pb.v) exp_bd[d] = pb.d;
         end
         exp_busy[d] = (cnt_m[d] > 0);
      end
   endtask

   // One clock: model update at the edge, compare 1 time unit later
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      if (checking) begin
         chk("busy0", busy0, exp_busy[0]);
         chk("busy1", busy1, exp_busy[1]);
         chk("a_valid0", a_valid0, exp_av[0]);
         chk("a_valid1", a_valid1, exp_av[1]);
         chk("b_valid0", b_valid0, exp_bv[0]);
         chk("b_valid1", b_valid1, exp_bv[1]);
         chk("a_dout0", a_dout0, exp_ad[0]);
         chk("a_dout1", a_dout1, exp_ad[1]);
         chk("b_dout0", b_dout0, exp_bd[0]);
         chk("b_dout1", b_dout1, exp_bd[1]);
      end
   endtask

   task automatic idle();
      a_cs = 1'b0;
      a_we = 1'b0;
      b_cs = 1'b0;
   endtask

   // ---------------- main test ----------------
   initial begin
      vec_t vecs [10];
      int   n, n1;

      vecs[0] = '{1'b1, 2'b11, 4'd5,  16'hABCD, 4'd5,  16'h0000, 16'hABCD, 16'h0000, 16'hABCD};
      vecs[1] = '{1'b1, 2'b01, 4'd5,  16'h1234, 4'd5,  16'hABCD, 16'hAB34, 16'hABCD, 16'hAB34};
      vecs[2] = '{1'b0, 2'b00, 4'd5,  16'h0000, 4'd5,  16'hAB34, 16'hAB34, 16'hAB34, 16'hAB34};
      vecs[3] = '{1'b1, 2'b11, 4'd3,  16'h1111, 4'd0,  16'h0000, 16'h1111, 16'h0000, 16'h0000};
      vecs[4] = '{1'b1, 2'b11, 4'd3,  16'h2222, 4'd3,  16'h1111, 16'h2222, 16'h1111, 16'h2222};
      vecs[5] = '{1'b1, 2'b00, 4'd3,  16'h5678, 4'd3,  16'h2222, 16'h2222, 16'h2222, 16'h2222};
      vecs[6] = '{1'b1, 2'b11, 4'd13, 16'hBEEF, 4'd13, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[7] = '{1'b0, 2'b00, 4'd13, 16'h0000, 4'd13, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000};
      vecs[8] = '{1'b1, 2'b10, 4'd11, 16'hFFFF, 4'd12, 16'h0000, 16'hFF00, 16'h0000, 16'h0000};
      vecs[9] = '{1'b0, 2'b00, 4'd11, 16'h0000, 4'd11, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};

      // Clear after a 3-cycle reset: busy length, then all words read as zero
      rst = 1'b1;
      repeat (3) cycle();
      checking = 1'b1;
      chk("rst_dout", {a_dout0, b_dout0}, 32'h0);
      chk("rst_valid", {a_valid0, b_valid0, a_valid1, b_valid1}, 32'h0);
      rst = 1'b0;
      n = 0;
      n1 = 0;
      while (busy0 && n < 100) begin
         n++;
         if (busy1) n1++;
         cycle();
      end
      chk("clear_busy_len0", n, 16);
      chk("clear_busy_len1", n1, 12);
      b_cs = 1'b1;
      for (int i = 0; i < 16; i++) begin
         b_addr = AW'(i);
         cycle();
         chk("clear_read", {b_valid0, b_dout0}, {15'h0, 1'b1, 16'h0000});
      end
      idle();
      cycle();

      // Table: one command cycle, two idle cycles, then the held outputs
      for (int i = 0; i < 10; i++) begin
         a_cs = 1'b1;
         a_we = vecs[i].a_we;
         a_be = vecs[i].be;
         a_addr = vecs[i].aa;
         a_din = vecs[i].din;
         b_cs = 1'b1;
         b_addr = vecs[i].ba;
         cycle();
         idle();
         cycle();
         cycle();
         chk($sformatf("vec%0d_a0", i), a_dout0, vecs[i].ea0);
         chk($sformatf("vec%0d_a1", i), a_dout1, vecs[i].ea1);
         chk($sformatf("vec%0d_b0", i), b_dout0, vecs[i].eb0);
         chk($sformatf("vec%0d_b1", i), b_dout1, vecs[i].eb1);
      end

      // Back-to-back B reads through the 2-stage pipeline of dut1
      a_cs = 1'b1;
      a_we = 1'b1;
      a_be = 2'b11;
      for (int i = 1; i <= 3; i++) begin
         a_addr = AW'(i);
         a_din = 16'(i * 16'h1001);
         cycle();
      end
      idle();
      b_cs = 1'b1;
      b_addr = 4'd1;
      cycle();
      chk("pipe_e1_v", b_valid1, 1'b0);
      chk("pipe_e1_dut0", {b_valid0, b_dout0}, {15'h0, 1'b1, 16'h1001});
      b_addr = 4'd2;
      cycle();
      chk("pipe_e2", {b_valid1, b_dout1}, {15'h0, 1'b1, 16'h1001});
      b_addr = 4'd3;
      cycle();
      chk("pipe_e3", {b_valid1, b_dout1}, {15'h0, 1'b1, 16'h2002});
      b_cs = 1'b0;
      cycle();
      chk("pipe_e4", {b_valid1, b_dout1}, {15'h0, 1'b1, 16'h3003});
      cycle();
      chk("pipe_hold", {b_valid1, b_dout1}, {15'h0, 1'b0, 16'h3003});

      // Reset in the middle of the sweep, with writes attempted while busy
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (7) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      n = 0;
      while (busy0 && n < 100) begin
         a_cs = 1'b1;
         a_we = 1'b1;
         a_be = 2'b11;
         a_addr = AW'($urandom_range(0, 15));
         a_din = DW'($urandom);
         n++;
         cycle();
      end
      idle();
      chk("rst_mid_clear_busy_len", n, 16);
      b_cs = 1'b1;
      for (int i = 0; i < 12; i++) begin
         b_addr = AW'(i);
         cycle();
         chk("mid_clear_read0", b_dout0, 16'h0000);
      end
      idle();
      cycle();

`ifdef GENERIC_MEM_PARITY_EN
      // Injected parity error on byte 0, then a clean rewrite
      a_cs = 1'b1; a_we = 1'b1; a_be = 2'b01; a_addr = 4'd7; a_din = 16'h00FF;
      a_perr_inj = 1'b1;
      cycle();
      a_perr_inj = 1'b0;
      a_we = 1'b0;
      cycle();
      chk("perr_inj_a0", {a_valid0, a_perr0}, {29'h0, 1'b1, 2'b01});
      idle();
      cycle();
      chk("perr_inj_a1", {a_valid1, a_perr1}, {29'h0, 1'b1, 2'b01});
      a_cs = 1'b1; a_we = 1'b1; a_be = 2'b01; a_addr = 4'd7; a_din = 16'h00FF;
      cycle();
      a_we = 1'b0;
      cycle();
      chk("perr_clean_a0", {a_valid0, a_perr0}, {29'h0, 1'b1, 2'b00});
      idle();
      cycle();
      chk("perr_clean_a1", {a_valid1, a_perr1}, {29'h0, 1'b1, 2'b00});
`endif

      // Random traffic against the model, with occasional resets
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         a_cs = 1'($urandom_range(0, 1));
         a_we = 1'($urandom_range(0, 1));
         a_be = NB'($urandom_range(0, 3));
         a_addr = AW'($urandom_range(0, 15));
         a_din = DW'($urandom);
         b_cs = 1'($urandom_range(0, 1));
         b_addr = ($urandom_range(0, 3) == 0) ? a_addr : AW'($urandom_range(0, 15));
         cycle();
      end
      rst = 1'b0;
      idle();
      repeat (3) cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Watchdog against a stuck run
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/generic_sync_dp_mem.md
Name: generic_sync_dp_mem

Overview:
Parametrised simple-dual-port synchronous RAM. It is the successor of the single-port generic sync memory.
- Port A: read/write with byte enables.
- Port B: read-only.
- Configurable read-during-write mode and an optional output register stage, with a read-valid strobe per port.
- A built-in clear sequencer zeroes the array after reset.
- Used as the register-file, scratchpad and FIFO backing store.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, address width.
RAM_DEPTH, 1 << ADDR_WIDTH, number of words; must be ≤ 2**ADDR_WIDTH.
READ_MODE, 0, same-address read during a port-A write: 0 = read-first (old data), 1 = write-first (new data).
OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
CLEAR_VALUE, 0, word written to every location by the clear sequencer.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
busy  out  1  high while reset or clear is in progress; accesses are ignored.
a_cs  in  1  port A select.
a_we  in  1  port A write enable; qualified by a_cs.
a_be  in  DATA_WIDTH/8  port A byte enables; bit i covers bits [8i+7:8i].
a_addr  in  ADDR_WIDTH  port A address.
a_din  in  DATA_WIDTH  port A write data.
a_dout  out  DATA_WIDTH  port A read data.
a_valid  out  1  one-cycle pulse; a_dout holds a new read result.
b_cs  in  1  port B read select.
b_addr  in  ADDR_WIDTH  port B address.
b_dout  out  DATA_WIDTH  port B read data.
b_valid  out  1  one-cycle pulse; b_dout holds a new read result.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset:
  - a_dout, b_dout, a_valid, b_valid and the output-stage registers all go to 0.
  - busy goes to 1; the FSM enters CLEAR and the clear pointer goes to 0.
  - The array contents are not reset directly.
- FSM, state CLEAR (entered on every cycle rst is high):
  - Each cycle with rst low: write CLEAR_VALUE to mem[ptr], then ptr++.
  - On the cycle that writes ptr = RAM_DEPTH-1, go to RUN.
  - busy stays high for exactly RAM_DEPTH cycles after rst falls, then drops.
  - rst asserted mid-clear restarts the sweep at address 0.
- FSM, state RUN: busy = 0. Leave RUN only via rst.
- While busy = 1:
  - a_cs and b_cs are ignored: no write, no read, valid stays 0.
  - A command presented in the same cycle busy falls is accepted.
- Port A write (a_cs & a_we, RUN):
  - Byte i of mem[a_addr] is updated only if a_be[i] = 1.
  - a_be = 0 writes nothing.
- Port A read (a_cs, RUN, with or without a_we):
  - Read-first: a_dout returns the pre-write word.
  - Write-first: a_dout returns the merged word (enabled bytes new, others old).
- Port B read (b_cs, RUN):
  - Returns mem[b_addr].
  - If port A writes the same address in the same cycle, READ_MODE applies identically to port B.
- Latency:
  - OUT_REG = 0: data and valid appear on the edge after the command (1 cycle).
  - OUT_REG = 1: data and valid appear 2 cycles after the command. Fully pipelined, one read per port per cycle.
- Data hold:
  - dout holds its last read value when no read completes.
  - valid is high only for the cycle new data is presented.
- rst mid-read: in-flight reads are discarded; valid does not fire; dout = 0.
- Address ≥ RAM_DEPTH (non-power-of-two depth): writes are dropped; reads return 0 with valid asserted.

Optional Feature:
GENERIC_MEM_PARITY_EN:
- Defined:
  - One even-parity bit is stored per byte, computed from the written byte; the clear sequencer writes matching parity.
  - Adds outputs a_perr and b_perr (width DATA_WIDTH/8). A bit is set when the stored parity of that byte mismatches; aligned with and qualified by the port's valid.
  - Adds input a_perr_inj (1 bit). When set with a port-A write, the stored parity of every enabled byte is inverted.
- Undefined: no parity storage, no perr/inj ports, no extra logic.

Test Plan:
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=4 unless noted.
1. Clear: rst high 3 cycles, then low → busy = 1 for exactly 16 cycles; port B then reads addr 0..15 → b_dout = 0x0000, b_valid = 1 each (1-cycle latency).
2. Byte enables: write 0xABCD to addr 5 with a_be = 2'b11, then write 0x1234 with a_be = 2'b01 → B read of addr 5 returns 0xAB34.
3. Read-during-write: mem[3] = 0x1111; A writes 0x2222 to addr 3 while B reads addr 3 → b_dout = 0x1111 (READ_MODE=0) or 0x2222 (READ_MODE=1).
4. OUT_REG=1 back-to-back reads of addr 1, 2, 3 → b_valid high on cycles +2, +3, +4 with data in order; b_dout holds the addr-3 value afterwards.
5. Reset mid-clear: assert rst at clear cycle 7 → busy stays high; sweep restarts; busy falls 16 cycles after the second rst release. A commands during busy leave mem unchanged.
6. With GENERIC_MEM_PARITY_EN: write 0x00FF with a_be = 2'b01 and a_perr_inj = 1, then read → a_perr = 2'b01 with a_valid; a clean rewrite of the same word → a_perr = 2'b00.
